// File: rtl/expansion_pkg.sv
// Shared constants and helpers for the serial I/O expander engine.
package expansion_pkg;

  // Frame sequencer state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_LO = 3'd1;
  localparam logic [2:0] ST_LOAD_HI = 3'd2;
  localparam logic [2:0] ST_CLK_LO  = 3'd3;
  localparam logic [2:0] ST_CLK_HI  = 3'd4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/expansion_tick_div.sv
// Free-running divider: tick is high on the last count of every CLK_DIV-cycle period.
module expansion_tick_div
  import expansion_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic rst_n,
  output logic tick
);

  localparam int              DW       = clog2_min1(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_r;

  assign tick = (div_r == DIV_LAST);

  // Count 0..CLK_DIV-1 and wrap on the tick cycle.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (tick) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

endmodule

// File: rtl/expansion_shiftreg.sv
// Serial I/O expander: shifts a parallel word into a 595-style output chain while
// reading a word back from a 165-style input chain, frame after frame.
module expansion_shiftreg
  import expansion_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             in_valid,
  output logic             EXPANSION0_SHIFTREG_CLOCK,
  output logic             EXPANSION0_SHIFTREG_LOAD,
  output logic             EXPANSION0_SHIFTREG_OUT,
  input  logic             EXPANSION0_SHIFTREG_IN
);

  localparam int            BW       = clog2_min1(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic             tick_s;
  logic [2:0]       state_r;
  logic [BW-1:0]    bit_r;
  logic [WIDTH-1:0] tx_r;
  logic [WIDTH-1:0] rx_r;
  logic [WIDTH-1:0] tx_shift_s;
  logic [WIDTH-1:0] rx_shift_s;
  logic [WIDTH-1:0] in_ext_s;

  expansion_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // MSB-first transmit; received bits enter at the LSB so the first bit ends up on top.
  assign in_ext_s   = WIDTH'(EXPANSION0_SHIFTREG_IN);
  assign tx_shift_s = tx_r << 1'b1;
  assign rx_shift_s = (rx_r << 1'b1) | in_ext_s;

  // Frame sequencer: every state change happens on a divider tick; in_valid self-clears.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                   <= ST_IDLE;
      bit_r                     <= '0;
      tx_r                      <= '0;
      rx_r                      <= '0;
      data_in                   <= '0;
      in_valid                  <= 1'b0;
      EXPANSION0_SHIFTREG_CLOCK <= 1'b0;
      EXPANSION0_SHIFTREG_LOAD  <= 1'b1;
      EXPANSION0_SHIFTREG_OUT   <= 1'b0;
    end else begin
      in_valid <= 1'b0;
      if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            tx_r                      <= data_out;
            EXPANSION0_SHIFTREG_LOAD  <= 1'b0;
            EXPANSION0_SHIFTREG_CLOCK <= 1'b0;
            state_r                   <= ST_LOAD_LO;
          end
          ST_LOAD_LO: begin
            // LOAD rising latches the previous frame into the 595 outputs.
            EXPANSION0_SHIFTREG_LOAD <= 1'b1;
            EXPANSION0_SHIFTREG_OUT  <= tx_r[WIDTH-1];
            state_r                  <= ST_LOAD_HI;
          end
          ST_LOAD_HI: begin
            bit_r   <= '0;
            state_r <= ST_CLK_LO;
          end
          ST_CLK_LO: begin
            // Sample the 165 output before the rising edge shifts it.
            rx_r                      <= rx_shift_s;
            EXPANSION0_SHIFTREG_CLOCK <= 1'b1;
            state_r                   <= ST_CLK_HI;
          end
          ST_CLK_HI: begin
            EXPANSION0_SHIFTREG_CLOCK <= 1'b0;
            if (bit_r != BIT_LAST) begin
              bit_r                   <= bit_r + BW'(1);
              tx_r                    <= tx_shift_s;
              EXPANSION0_SHIFTREG_OUT <= tx_shift_s[WIDTH-1];
              state_r                 <= ST_CLK_LO;
            end else begin
              data_in                  <= rx_r;
              in_valid                 <= 1'b1;
              tx_r                     <= data_out;
              EXPANSION0_SHIFTREG_LOAD <= 1'b0;
              state_r                  <= ST_LOAD_LO;
            end
          end
          default: begin
            state_r                   <= ST_IDLE;
            EXPANSION0_SHIFTREG_CLOCK <= 1'b0;
            EXPANSION0_SHIFTREG_LOAD  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expansion_shiftreg.sv
// Bench for expansion_shiftreg: three configurations (8/2, 1/1, 4/5) run side by side
// against a frame-timeline model plus pin-level 165/595 device models.
module tb_expansion_shiftreg;

  function automatic int w_of(input int i);
    case (i)
      0:       return 8;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int d_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] dout [3];
  logic [7:0] par  [3];
  logic [7:0] din  [3];
  logic [7:0] q165 [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] vld, sclk, sload, sout;

  int checks   = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = w_of(g);
    localparam int D = d_of(g);
    logic [W-1:0] di_s;
    expansion_shiftreg #(.WIDTH(W), .CLK_DIV(D)) u_dut (
      .sysclk                   (sysclk),
      .rst_n                    (rst_n),
      .data_out                 (dout[g][W-1:0]),
      .data_in                  (di_s),
      .in_valid                 (vld[g]),
      .EXPANSION0_SHIFTREG_CLOCK(sclk[g]),
      .EXPANSION0_SHIFTREG_LOAD (sload[g]),
      .EXPANSION0_SHIFTREG_OUT  (sout[g]),
      .EXPANSION0_SHIFTREG_IN   (q165[g][W-1])
    );
    assign din[g] = 8'(di_s);
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Model state (per configuration)
  int         k [3]          = '{0, 0, 0};
  logic [7:0] snap_cur [3]   = '{8'h00, 8'h00, 8'h00};
  logic [7:0] snap_prev [3]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] cap_cur [3]    = '{8'h00, 8'h00, 8'h00};
  logic [7:0] cap_prev [3]   = '{8'h00, 8'h00, 8'h00};
  logic [7:0] exp_din [3]    = '{8'h00, 8'h00, 8'h00};
  logic [7:0] last_dout [3]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] sr595 [3]      = '{8'h00, 8'h00, 8'h00};
  logic       prev_clk [3]   = '{1'b0, 1'b0, 1'b0};
  logic       prev_load [3]  = '{1'b1, 1'b1, 1'b1};
  int         vcnt [3]       = '{0, 0, 0};
  int         vlast [3]      = '{0, 0, 0};
  int         hrun           = 0;
  int         latch_cnt0     = 0;
  logic       rst_prev       = 1'b0;

  // Single compare process: advance the frame timeline, check every pin, run device models.
  always @(negedge sysclk) begin
    for (int i = 0; i < 3; i++) begin
      int W, D, S, m, slot, f, b;
      logic e_load, e_clk, e_out, e_val;
      logic [7:0] mask;
      W = w_of(i); D = d_of(i); S = 2 * W + 2;
      mask = 8'((1 << W) - 1);
      f = 0;
      if (!rst_n) begin
        k[i] = 0;
        exp_din[i] = 8'h00;
        chk("rst_clock", i, sclk[i], 1'b0);
        chk("rst_load", i, sload[i], 1'b1);
        chk("rst_out", i, sout[i], 1'b0);
        chk("rst_valid", i, vld[i], 1'b0);
        chk("rst_data_in", i, din[i], 8'h00);
        if (i == 2) hrun = 0;
      end else begin
        if (rst_prev) k[i] = k[i] + 1; else k[i] = 0;
        e_val = 1'b0;
        if (k[i] < D) begin
          e_load = 1'b1; e_clk = 1'b0; e_out = 1'b0;
        end else begin
          m = k[i] / D - 1; slot = m % S; f = m / S;
          if ((k[i] % D) == 0 && slot == 0) begin
            snap_prev[i] = snap_cur[i];
            snap_cur[i]  = last_dout[i];
            cap_prev[i]  = cap_cur[i];
            if (f >= 1) begin
              e_val = 1'b1;
              exp_din[i] = cap_prev[i] & mask;
            end
          end
          if (slot == 0) cap_cur[i] = par[i];
          e_load = (slot != 0);
          e_clk  = (slot >= 3) && (slot % 2 == 1);
          if (slot == 0) begin
            e_out = (f == 0) ? 1'b0 : snap_prev[i][0];
          end else begin
            b = (slot < 2) ? 0 : (slot - 2) / 2;
            e_out = snap_cur[i][W-1-b];
          end
        end
        chk("clock", i, sclk[i], e_clk);
        chk("load", i, sload[i], e_load);
        chk("out", i, sout[i], e_out);
        chk("in_valid", i, vld[i], e_val);
        chk("data_in", i, din[i], exp_din[i]);
        // Hand-derived anchors for the first frames
        if (vld[i]) begin
          vcnt[i]++;
          if (i == 0 && vcnt[i] == 1) chk("first_word_3C", i, din[i], 8'h3C);
          if (i == 0 && vcnt[i] == 2) chk("frame_period_36", i, k[i] - vlast[i], 36);
          if (i == 1 && vcnt[i] == 2) chk("frame_period_4", i, k[i] - vlast[i], 4);
          vlast[i] = k[i];
        end
        if (i == 2) begin
          if (sclk[2]) hrun++;
          else if (hrun > 0) begin
            chk("clock_high_5", i, hrun, 5);
            hrun = 0;
          end
        end
      end
      // 595 chain: shift on CLOCK rise, latch on LOAD rise
      if (!prev_clk[i] && sclk[i]) sr595[i] = {sr595[i][6:0], sout[i]};
      if (!prev_load[i] && sload[i] && rst_n && k[i] >= D && f >= 1) begin
        chk("latch595", i, sr595[i] & mask, snap_prev[i] & mask);
        if (i == 0) begin
          if (latch_cnt0 == 0) chk("first_latch_A5", i, sr595[i], 8'hA5);
          latch_cnt0++;
        end
      end
      // 165 chain: parallel load while LOAD low, shift on CLOCK rise
      if (!sload[i]) q165[i] = par[i];
      else if (!prev_clk[i] && sclk[i]) q165[i] = q165[i] << 1;
      prev_clk[i]  = sclk[i];
      prev_load[i] = sload[i];
      last_dout[i] = dout[i];
    end
    rst_prev = rst_n;
  end

  task automatic step();
    @(posedge sysclk);
    #2;
  endtask

  task automatic wait_k(input int t);
    for (int n = 0; n < 400 && k[0] < t; n++) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      dout[i] = 8'($urandom);
      par[i]  = 8'($urandom);
    end
    dout[0] = 8'hA5;
    par[0]  = 8'h3C;
    rst_n   = 1'b0;
    repeat (10) step();
    rst_n = 1'b1;
    // Mid-frame data_out changes must only take effect at the next snapshot
    wait_k(20);
    dout[0] = 8'hFF;
    wait_k(56);
    dout[0] = 8'h00;
    wait_k(150);
    // Reset during bit 4 of a frame on the 8/2 instance
    for (int n = 0; n < 100; n++) begin
      step();
      if (k[0] >= 2 && ((k[0] / 2 - 1) % 18) == 10) break;
    end
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    // Randomized traffic; 165 inputs only move while LOAD is high
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 15) == 0) dout[i] = 8'($urandom);
        if (sload[i] && $urandom_range(0, 7) == 0) par[i] = 8'($urandom);
      end
    end
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
